// File: rtl/psum_accumulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : psum_acc_pkg                                               |
// | Description : Shared types and default widths for the partial-sum       |
// |               accumulator that follows fusion_unit.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package psum_acc_pkg;

  // Default widths; the accumulator must be at least one bit wider than a product.
  localparam int DEF_PSUM_W  = 19;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_MAX_LEN = 256;

  // Saturation rails of the default-width accumulator, for downstream consumers.
  localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  // Run controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage : psum_acc_pkg
`default_nettype wire

// File: rtl/psum_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : psum_accumulator_if                                        |
// | Description : Run control, product stream and result handshake of the   |
// |               partial-sum accumulator. The accumulator is the slave.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface psum_accumulator_if #(
  parameter int PSUM_W = 19,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 9
);

  // Run control from the upstream controller
  logic              start;
  logic [LEN_W-1:0]  len;

  // Product stream from fusion_unit
  logic [PSUM_W-1:0] psum_in;
  logic              psum_valid;

  // Result channel and status
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;
  logic              sat;
  logic              busy;
  logic              drop;

  // Controller / producer / result consumer side
  modport master (
    output start, len, psum_in, psum_valid, out_ready,
    input  acc_out, out_valid, sat, busy, drop
  );

  // Accumulator side
  modport slave (
    input  start, len, psum_in, psum_valid, out_ready,
    output acc_out, out_valid, sat, busy, drop
  );

endinterface : psum_accumulator_if
`default_nettype wire

// File: rtl/psum_accumulator_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psum_sat_add                                               |
// | Description : Sign-extends a product to accumulator width, adds it to    |
// |               the running sum and clamps to the signed range, flagging   |
// |               any clamp on ovf.                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module psum_sat_add #(
  parameter int PSUM_W = 19,
  parameter int ACC_W  = 32
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PSUM_W-1:0] psum_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit above the accumulator is enough: both operands fit in ACC_W.
  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] psum_ext;
  logic [ACC_W:0] raw_sum;

  // Exact sum in ACC_W+1 bits, then clamp when the guard and sign bits disagree.
  always_comb begin
    acc_ext  = {acc_in[ACC_W-1], acc_in};
    psum_ext = {{(ACC_W+1-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
    raw_sum  = acc_ext + psum_ext;
    ovf      = raw_sum[ACC_W] ^ raw_sum[ACC_W-1];
    if (!ovf) begin
      sum_out = raw_sum[ACC_W-1:0];
    end else if (raw_sum[ACC_W]) begin
      sum_out = SAT_MIN;
    end else begin
      sum_out = SAT_MAX;
    end
  end

endmodule : psum_sat_add
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psum_accumulator                                           |
// | Description : Sums a programmed number of signed products from           |
// |               fusion_unit into a saturating accumulator and presents one |
// |               dot-product result per run on a valid/ready channel.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  psum_accumulator_if.slave bus
);

  state_e            state_q,     state_d;
  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic [LEN_W-1:0]  cnt_q,       cnt_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [ACC_W-1:0]  acc_out_q,   acc_out_d;
  logic              out_valid_q, out_valid_d;
  logic              sat_q,       sat_d;
  logic              drop_q,      drop_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;
  logic              launch;

  // Oversized run lengths are treated as the largest supported run.
  assign len_clamped = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

  psum_sat_add #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc_in  (acc_q),
    .psum_in (bus.psum_in),
    .sum_out (sum),
    .ovf     (sum_ovf)
  );

  // Next-state logic: accumulate in ACCUM, hold the result in HOLD, and
  // launch a new run from IDLE or on the HOLD handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    drop_d      = bus.psum_valid & (state_q != ST_ACCUM);
    launch      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        launch = bus.start;
      end
      ST_ACCUM: begin
        if (bus.psum_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + LEN_W'(1);
          if (sum_ovf) begin
            sat_d = 1'b1;
          end
          // The final product goes straight into the result register so the
          // result appears on the edge that consumes it.
          if (cnt_q == len_q - LEN_W'(1)) begin
            acc_out_d   = sum;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          if (bus.start) begin
            launch = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A zero-length run skips accumulation and reports an empty sum.
    if (launch) begin
      sat_d = 1'b0;
      if (len_clamped == '0) begin
        acc_out_d   = '0;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end else begin
        acc_d       = '0;
        cnt_d       = '0;
        len_d       = len_clamped;
        out_valid_d = 1'b0;
        state_d     = ST_ACCUM;
      end
    end
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule : psum_accumulator
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_psum_accumulator                                        |
// | Description : Scoreboard bench for psum_accumulator. Expected results    |
// |               come from a saturating integer sum of each run's products; |
// |               a monitor compares them whenever a result is presented.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_psum_accumulator;

  localparam int PSUM_W  = 19;
  localparam int ACC_W   = 20;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  localparam longint SAT_HI = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint SAT_LO = -(longint'(1) <<< (ACC_W - 1));
  localparam int     P_HI   = (1 << (PSUM_W - 1)) - 1;
  localparam int     P_LO   = -(1 << (PSUM_W - 1));

  typedef struct {
    longint acc;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t exp_q[$];
  exp_t mon_e;
  int   prods[512];
  int   checks = 0;
  int   errors = 0;
  bit   in_hold;

  always #5 clk = ~clk;

  psum_accumulator_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  psum_accumulator #(
    .PSUM_W  (PSUM_W),
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rand_prod(input int mode);
    case (mode)
      0:       return int'($urandom_range(0, 200)) - 100;
      1:       return int'($urandom_range(0, (1 << PSUM_W) - 1)) + P_LO;
      default: return ($urandom_range(0, 1) == 1) ? P_HI - int'($urandom_range(0, 3))
                                                  : P_LO + int'($urandom_range(0, 3));
    endcase
  endfunction

  // Issue a run of length l using prods[]; optionally launch it on the HOLD handshake.
  task automatic run(input int l, input int max_gap, input bit accept_now);
    int     n;
    longint s;
    bit     sf;
    exp_t   e;
    n  = (l > MAX_LEN) ? MAX_LEN : l;
    s  = 0;
    sf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + prods[i];
      if (s > SAT_HI) begin s = SAT_HI; sf = 1'b1; end
      if (s < SAT_LO) begin s = SAT_LO; sf = 1'b1; end
    end
    e.acc = s;
    e.sat = sf;
    exp_q.push_back(e);

    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    if (accept_now) bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b0;
    if (n == 0) begin
      chk("len0_latency", bus.out_valid, 1);
    end else if (accept_now) begin
      chk("b2b_no_idle_busy", bus.busy, 1);
    end

    for (int i = 0; i < n; i++) begin
      int g;
      g = int'($urandom_range(0, max_gap));
      for (int k = 0; k < g; k++) begin
        bus.psum_valid = 1'b0;
        bus.psum_in    = PSUM_W'($urandom);
        @(posedge clk); #1;
      end
      if (i == n - 1) chk("no_early_result", bus.out_valid, 0);
      bus.psum_valid = 1'b1;
      bus.psum_in    = PSUM_W'(prods[i]);
      @(posedge clk); #1;
      bus.psum_valid = 1'b0;
    end
    if (n > 0) chk("result_latency", bus.out_valid, 1);
  endtask

  // Stall the result for a while (optionally offering a product that must be
  // dropped), then accept it and return to IDLE.
  task automatic drain(input int stall, input bit poke);
    chk("hold_valid", bus.out_valid, 1);
    for (int k = 0; k < stall; k++) begin
      if (poke && k == 0) begin
        bus.psum_valid = 1'b1;
        bus.psum_in    = PSUM_W'($urandom);
      end
      @(posedge clk); #1;
      if (poke && k == 0) begin
        bus.psum_valid = 1'b0;
        chk("drop_in_hold", bus.drop, 1);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_falls", bus.out_valid, 0);
    chk("idle_after_accept", bus.busy, 0);
  endtask

  // Scoreboard monitor: peeks while a result is stalled, pops on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got acc_out %0d, expected no result",
                   longint'($signed(bus.acc_out)));
        end else begin
          mon_e = exp_q[0];
          chk(bus.out_ready ? "result_acc" : "held_acc",
              longint'($signed(bus.acc_out)), mon_e.acc);
          chk(bus.out_ready ? "result_sat" : "held_sat", bus.sat, mon_e.sat);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog: a stuck run must still end the simulation.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.psum_in    = '0;
    bus.psum_valid = 1'b0;
    bus.out_ready  = 1'b0;
    in_hold        = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_acc_out",   longint'($signed(bus.acc_out)), 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_sat",       bus.sat, 0);
    chk("reset_busy",      bus.busy, 0);
    chk("reset_drop",      bus.drop, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic run: 100 - 3 - 256 + 5 = -154
    prods[0] = 100; prods[1] = -3; prods[2] = -256; prods[3] = 5;
    run(4, 0, 1'b0);
    drain(0, 1'b0);

    // Gapped products and backpressure
    prods[0] = 1; prods[1] = 2; prods[2] = 3;
    run(3, 3, 1'b0);
    drain(5, 1'b1);

    // Saturation at the positive rail, then a clean run clears sat
    for (int i = 0; i < 8; i++) prods[i] = P_HI;
    run(8, 0, 1'b0);
    drain(2, 1'b0);
    prods[0] = -5;
    run(1, 1, 1'b0);
    drain(0, 1'b0);

    // Back-to-back runs launched on the handshake
    prods[0] = rand_prod(0); prods[1] = rand_prod(0);
    run(2, 0, 1'b0);
    prods[0] = 7; prods[1] = 8;
    run(2, 0, 1'b1);
    drain(1, 1'b0);

    // Edge lengths
    run(0, 0, 1'b0);
    drain(0, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) prods[i] = -1;
    run(MAX_LEN, 0, 1'b0);
    drain(0, 1'b0);
    for (int i = 0; i < 300; i++) prods[i] = rand_prod(0);
    run(300, 0, 1'b0);
    drain(0, 1'b0);

    // Reset in the middle of a run discards it
    bus.start = 1'b1;
    bus.len   = LEN_W'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
    for (int i = 0; i < 2; i++) begin
      bus.psum_valid = 1'b1;
      bus.psum_in    = PSUM_W'(rand_prod(1));
      @(posedge clk); #1;
    end
    bus.psum_valid = 1'b0;
    chk("busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_out_valid", bus.out_valid, 0);
    chk("midrun_reset_busy",      bus.busy, 0);
    chk("midrun_reset_acc_out",   longint'($signed(bus.acc_out)), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Product offered in IDLE is dropped and does not disturb the next run
    bus.psum_valid = 1'b1;
    bus.psum_in    = PSUM_W'(12345);
    @(posedge clk); #1;
    bus.psum_valid = 1'b0;
    chk("drop_in_idle", bus.drop, 1);
    @(posedge clk); #1;
    chk("drop_one_cycle", bus.drop, 0);
    prods[0] = 9;
    run(1, 0, 1'b0);
    drain(0, 1'b0);

    // Randomized runs with mixed lengths, gaps, stalls and back-to-back launches
    for (int r = 0; r < 30; r++) begin
      int l;
      int mode;
      l    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300))
                                         : int'($urandom_range(0, 12));
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 300; i++) prods[i] = rand_prod(mode);
      if (in_hold && $urandom_range(0, 1) == 1) begin
        run(l, int'($urandom_range(0, 2)), 1'b1);
      end else begin
        if (in_hold) drain(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
        run(l, int'($urandom_range(0, 2)), 1'b0);
      end
      in_hold = 1'b1;
    end
    drain(1, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_psum_accumulator
`default_nettype wire
